sort_initiator: RTL and testbench
=================================

SORT_INITIATOR -- requirements
Module: sort_initiator

Interface
REQ-001 SHALL have parameter BASE, default 5'd0, meaning the data-memory word address of array element 0.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to sort; sampled only in IDLE.
REQ-005 SHALL have port len  input  5  element count, sampled with start.
REQ-006 SHALL have port busy  output  1  high from the cycle after accepted start until DONE.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the sort completes.
REQ-008 SHALL have port swap_count  output  16  number of swaps performed by the last or current sort.
REQ-009 SHALL have port mem_addr  output  5  data-memory word address.
REQ-010 SHALL have port mem_mode  output  1  0 = write on this edge, 1 = read on this edge.
REQ-011 SHALL have port mem_wdata  output  32  write data.
REQ-012 SHALL have port mem_rdata  input  32  registered read data, valid the cycle after a read is issued.

Function
REQ-013 SHALL act as the initiator on the synchronous single-port data-memory interface and sort elements BASE..BASE+len-1 into ascending unsigned order in place.
REQ-014 SHALL drive mem_mode=1 in every state except WR_A and WR_B; the memory writes on every edge where mode=0.
REQ-015 SHALL implement the states IDLE, RD_A, RD_B, CMP, WR_A, WR_B and DONE.
REQ-016 SHALL stay in IDLE until start=1. With len<=1 it SHALL go directly to DONE with no memory access. Otherwise it SHALL clear the pass index p, inner index j and swap_count, then go to RD_A.
REQ-017 SHALL in RD_A issue a read of BASE+j. In RD_B it SHALL issue a read of BASE+j+1 and capture mem_rdata as A.
REQ-018 SHALL in CMP capture mem_rdata as B. It SHALL go to WR_A if A>B (unsigned, strictly greater), else advance.
REQ-019 SHALL in WR_A write B to BASE+j. In WR_B it SHALL write A to BASE+j+1, increment swap_count, then advance.
REQ-020 SHALL advance as follows: if j<len-2-p, then j=j+1 and go to RD_A. Otherwise, if p<len-2, then p=p+1, j=0 and go to RD_A. Otherwise go to DONE.
REQ-021 SHALL take 3 cycles per non-swapping compare and 5 cycles per swapping compare.
REQ-022 SHALL in DONE assert done for exactly one cycle, deassert busy and return to IDLE. swap_count SHALL hold until the next accepted start.
REQ-023 SHALL ignore start while busy.
REQ-024 SHALL compute addresses as BASE+index truncated to 5 bits (wraps modulo 32).
REQ-025 SHALL saturate swap_count at 16'hFFFF.

Reset
REQ-026 SHALL on rst_n=0 at a clock edge enter IDLE with busy=0, done=0, swap_count=0, mem_addr=0, mem_mode=1, mem_wdata=0.
REQ-027 SHALL abort a sort in progress on reset mid-operation. Memory contents SHALL be left as already written, and no further write SHALL be issued after the reset edge.

Configuration
REQ-028 SHALL, with macro SORT_EARLY_EXIT_EN defined, track a per-pass swap flag and go to DONE at the end of any pass that performed zero swaps.
REQ-029 SHALL, without SORT_EARLY_EXIT_EN, always execute all len-1 passes.

Verification
REQ-030 SHALL cover this case: BASE=0, memory[0..9]=78,456,1,89,13,56,267,102,3,51, start with len=10 -> memory[0..9]=1,3,13,51,56,78,89,102,267,456; swap_count=25; one done pulse.
REQ-031 SHALL cover this case: memory=1,2,3,4, len=4 -> mem_mode never 0 and swap_count=0. With SORT_EARLY_EXIT_EN, done after 3 compares (9 busy cycles). Without it, done after 6 compares (18 busy cycles).
REQ-032 SHALL cover this case: memory=5,3, len=2 -> memory=3,5, swap_count=1, exactly 2 write cycles at addresses 0 then 1.
REQ-033 SHALL cover this case: len=0 and len=1 -> done pulses 2 cycles after start, with no memory access and swap_count=0.
REQ-034 SHALL cover this case: rst_n=0 asserted in WR_A -> next cycle IDLE, mem_mode=1, busy=0, and memory at BASE+j+1 unchanged.
REQ-035 SHALL cover this case: BASE=30, len=4 -> accesses addresses 30,31,0,1, sorted correctly; start pulses while busy are ignored.

Source files
------------

// File: rtl/sort_initiator_if.sv
// Synchronous single-port data-memory bus between the sort initiator and its memory.
interface sort_initiator_if;
  logic [4:0]  mem_addr;
  logic        mem_mode;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (output mem_addr, output mem_mode, output mem_wdata, input mem_rdata);
  modport slave  (input mem_addr, input mem_mode, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/sort_initiator.sv
// In-place ascending bubble sort of a word array held in a single-port data memory.
// Optional macro SORT_EARLY_EXIT_EN ends the sort after the first pass with no swaps.
module sort_initiator #(
  parameter logic [4:0] BASE = 5'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  len,
  output logic        busy,
  output logic        done,
  output logic [15:0] swap_count,
  sort_initiator_if.master mem
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    CMP  = 3'd3,
    WR_A = 3'd4,
    WR_B = 3'd5,
    DONE = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  p_q, p_d;
  logic [4:0]  j_q, j_d;
  logic [4:0]  len_q, len_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [15:0] swap_q, swap_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [4:0]  addr_q, addr_d;
  logic        mode_q, mode_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef SORT_EARLY_EXIT_EN
  logic        pass_swap_q, pass_swap_d;
`endif

  logic [5:0]  j_limit;
  logic        last_j;
  logic        last_p;
  logic        do_adv;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      p_q     <= '0;
      j_q     <= '0;
      len_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      swap_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      mode_q  <= 1'b1;
      wdata_q <= '0;
`ifdef SORT_EARLY_EXIT_EN
      pass_swap_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      j_q     <= j_d;
      len_q   <= len_d;
      a_q     <= a_d;
      b_q     <= b_d;
      swap_q  <= swap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      wdata_q <= wdata_d;
`ifdef SORT_EARLY_EXIT_EN
      pass_swap_q <= pass_swap_d;
`endif
    end
  end

  // Inner loop ends when j reaches len-2-p; outer loop ends when p reaches len-2
  assign j_limit = {1'b0, len_q} - 6'd2 - {1'b0, p_q};
  assign last_j  = {1'b0, j_q} >= j_limit;
  assign last_p  = {1'b0, p_q} >= ({1'b0, len_q} - 6'd2);

  // Next state, loop indices and registered bus outputs (driven for the state being entered)
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    j_d     = j_q;
    len_d   = len_q;
    a_d     = a_q;
    b_d     = b_q;
    swap_d  = swap_q;
    do_adv  = 1'b0;
`ifdef SORT_EARLY_EXIT_EN
    pass_swap_d = pass_swap_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          p_d     = '0;
          j_d     = '0;
          swap_d  = '0;
`ifdef SORT_EARLY_EXIT_EN
          pass_swap_d = 1'b0;
`endif
          state_d = (len <= 5'd1) ? DONE : RD_A;
        end
      end
      RD_A: state_d = RD_B;
      RD_B: begin
        a_d     = mem.mem_rdata;
        state_d = CMP;
      end
      CMP: begin
        b_d = mem.mem_rdata;
        if (a_q > mem.mem_rdata) state_d = WR_A;
        else                     do_adv  = 1'b1;
      end
      WR_A: state_d = WR_B;
      WR_B: begin
        if (swap_q != 16'hFFFF) swap_d = swap_q + 16'd1;
`ifdef SORT_EARLY_EXIT_EN
        pass_swap_d = 1'b1;
`endif
        do_adv = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (do_adv) begin
      if (!last_j) begin
        j_d     = j_q + 5'd1;
        state_d = RD_A;
      end
`ifdef SORT_EARLY_EXIT_EN
      else if (!pass_swap_q && (state_q != WR_B)) begin
        state_d = DONE;
      end
`endif
      else if (!last_p) begin
        p_d     = p_q + 5'd1;
        j_d     = '0;
`ifdef SORT_EARLY_EXIT_EN
        pass_swap_d = 1'b0;
`endif
        state_d = RD_A;
      end else begin
        state_d = DONE;
      end
    end

    busy_d  = (state_d != IDLE) && (state_d != DONE);
    done_d  = (state_q == DONE);
    addr_d  = '0;
    mode_d  = 1'b1;
    wdata_d = '0;
    case (state_d)
      RD_A: addr_d = 5'(BASE + j_d);
      RD_B: addr_d = 5'(BASE + j_d + 5'd1);
      WR_A: begin
        addr_d  = 5'(BASE + j_d);
        mode_d  = 1'b0;
        wdata_d = b_d;
      end
      WR_B: begin
        addr_d  = 5'(BASE + j_d + 5'd1);
        mode_d  = 1'b0;
        wdata_d = a_q;
      end
      default: ;
    endcase
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign swap_count    = swap_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_mode  = mode_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_sort_initiator.sv
// Directed bench for sort_initiator: vector table on a BASE=0 instance plus reset and BASE=30 sequences.
module tb_sort_initiator;

  logic        clk;
  logic        rst_n;
  logic        start0, start1;
  logic [4:0]  len0, len1;
  logic        busy0, busy1, done0, done1;
  logic [15:0] swc0, swc1;

  sort_initiator_if bus0 ();
  sort_initiator_if bus1 ();

  sort_initiator #(.BASE(5'd0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .len(len0),
    .busy(busy0), .done(done0), .swap_count(swc0), .mem(bus0.master));

  sort_initiator #(.BASE(5'd30)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .len(len1),
    .busy(busy1), .done(done1), .swap_count(swc1), .mem(bus1.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [32];
  logic        ld_en, ld_sel, clr;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;

  int wr_cnt0, done_cnt0, busy_cyc0, done_cnt1, busy_cyc1, bad_addr1;
  logic [4:0]  wr_addr0 [2];
  logic [31:0] seen1;

  // Memory models: registered read, write when mode=0; bench loads take priority
  always @(posedge clk) begin
    if (ld_en && !ld_sel)   mem0[ld_addr] <= ld_data;
    else if (!bus0.mem_mode) mem0[bus0.mem_addr] <= bus0.mem_wdata;
    bus0.mem_rdata <= mem0[bus0.mem_addr];
    if (ld_en && ld_sel)     mem1[ld_addr] <= ld_data;
    else if (!bus1.mem_mode) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    bus1.mem_rdata <= mem1[bus1.mem_addr];
  end

  // Activity monitors
  always @(posedge clk) begin
    if (clr) begin
      wr_cnt0 <= 0; done_cnt0 <= 0; busy_cyc0 <= 0;
      done_cnt1 <= 0; busy_cyc1 <= 0; bad_addr1 <= 0; seen1 <= '0;
      wr_addr0[0] <= '0; wr_addr0[1] <= '0;
    end else begin
      if (!bus0.mem_mode) begin
        wr_cnt0 <= wr_cnt0 + 1;
        if (wr_cnt0 < 2) wr_addr0[wr_cnt0[0]] <= bus0.mem_addr;
      end
      if (done0) done_cnt0 <= done_cnt0 + 1;
      if (busy0) busy_cyc0 <= busy_cyc0 + 1;
      if (done1) done_cnt1 <= done_cnt1 + 1;
      if (busy1) begin
        busy_cyc1 <= busy_cyc1 + 1;
        seen1[bus1.mem_addr] <= 1'b1;
        if (!(bus1.mem_addr inside {5'd30, 5'd31, 5'd0, 5'd1})) bad_addr1 <= bad_addr1 + 1;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic load(input logic sel, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic clear_mon();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  // Pulse start on u0 and count negedges until done is seen
  task automatic run_sort0(input logic [4:0] l, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    @(negedge clk);
    start0 = 1'b1; len0 = l;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      n++;
      start0 = 1'b0;
      if (done0) begin got = 1'b1; break; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no done expected done within 2000 cycles");
    end
  endtask

  typedef struct {
    logic [4:0]  len;
    logic [31:0] init [10];
    logic [31:0] exp  [10];
    int          swaps;
    int          busy_full;
    int          busy_early;
  } vec_t;

  localparam int NV = 8;
  vec_t v [NV];

  initial begin
    int n, exp_busy, last_swaps;

    v[0] = '{5'd10, '{78,456,1,89,13,56,267,102,3,51}, '{1,3,13,51,56,78,89,102,267,456}, 25, 185, 182};
    v[1] = '{5'd4,  '{1,2,3,4,100,90,80,70,60,50},     '{1,2,3,4,100,90,80,70,60,50},     0,  18,  9};
    v[2] = '{5'd2,  '{5,3,100,90,80,70,60,50,40,30},   '{3,5,100,90,80,70,60,50,40,30},   1,  5,   5};
    v[3] = '{5'd0,  '{9,8,7,6,5,4,3,2,1,0},            '{9,8,7,6,5,4,3,2,1,0},            0,  0,   0};
    v[4] = '{5'd1,  '{9,8,7,6,5,4,3,2,1,0},            '{9,8,7,6,5,4,3,2,1,0},            0,  0,   0};
    v[5] = '{5'd4,  '{4,3,2,1,11,12,13,14,15,16},      '{1,2,3,4,11,12,13,14,15,16},      6,  30,  30};
    v[6] = '{5'd3,  '{32'hFFFF_FFFF,0,32'h7FFF_FFFF,7,7,7,7,7,7,7},
                    '{0,32'h7FFF_FFFF,32'hFFFF_FFFF,7,7,7,7,7,7,7},                        2,  13,  13};
    v[7] = '{5'd3,  '{2,2,1,8,8,8,8,8,8,8},            '{1,2,2,8,8,8,8,8,8,8},            2,  13,  13};

    rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; len0 = '0; len1 = '0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0; clr = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy0), 0);
    chk("rst_done",  32'(done0), 0);
    chk("rst_swaps", 32'(swc0), 0);
    chk("rst_addr",  32'(bus0.mem_addr), 0);
    chk("rst_mode",  32'(bus0.mem_mode), 1);
    chk("rst_wdata", bus0.mem_wdata, 0);
    chk("rst_mode1", 32'(bus1.mem_mode), 1);
    rst_n = 1'b1; clr = 1'b0;

    last_swaps = 0;
    for (int i = 0; i < NV; i++) begin
      for (int k = 0; k < 10; k++) load(1'b0, 5'(k), v[i].init[k]);
      clear_mon();
      run_sort0(v[i].len, n);
      repeat (3) @(negedge clk);
`ifdef SORT_EARLY_EXIT_EN
      exp_busy = v[i].busy_early;
`else
      exp_busy = v[i].busy_full;
`endif
      chk($sformatf("v%0d_swaps", i), 32'(swc0), 32'(v[i].swaps));
      chk($sformatf("v%0d_busy_cycles", i), 32'(busy_cyc0), 32'(exp_busy));
      chk($sformatf("v%0d_done_pulses", i), 32'(done_cnt0), 1);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(exp_busy + 2));
      chk($sformatf("v%0d_writes", i), 32'(wr_cnt0), 32'(2 * v[i].swaps));
      for (int k = 0; k < 10; k++)
        chk($sformatf("v%0d_mem%0d", i, k), mem0[k], v[i].exp[k]);
      if (v[i].len == 5'd2) begin
        chk($sformatf("v%0d_wr_addr0", i), 32'(wr_addr0[0]), 0);
        chk($sformatf("v%0d_wr_addr1", i), 32'(wr_addr0[1]), 1);
      end
      last_swaps = v[i].swaps;
    end

    repeat (10) @(negedge clk);
    chk("swaps_hold", 32'(swc0), 32'(last_swaps));

    // Reset asserted while in WR_A
    load(1'b0, 5'd0, 32'd5);
    load(1'b0, 5'd1, 32'd3);
    clear_mon();
    @(negedge clk); start0 = 1'b1; len0 = 5'd2;
    @(negedge clk); start0 = 1'b0;
    for (int t = 0; t < 20 && bus0.mem_mode; t++) @(negedge clk);
    chk("rst_reach_wr_a", 32'(bus0.mem_mode), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_mode",  32'(bus0.mem_mode), 1);
    chk("midrst_busy",  32'(busy0), 0);
    chk("midrst_done",  32'(done0), 0);
    chk("midrst_swaps", 32'(swc0), 0);
    repeat (4) @(negedge clk);
    chk("midrst_writes", 32'(wr_cnt0), 1);
    chk("midrst_mem1",   mem1[0] === mem1[0] ? mem0[1] : mem0[1], 3);
    chk("midrst_idle",   32'(busy0), 0);

    // BASE=30: wraps across address 0; start pulses while busy must be ignored
    load(1'b1, 5'd30, 32'd40);
    load(1'b1, 5'd31, 32'd10);
    load(1'b1, 5'd0,  32'd30);
    load(1'b1, 5'd1,  32'd20);
    clear_mon();
    n = 0;
    @(negedge clk); start1 = 1'b1; len1 = 5'd4;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      n++;
      len1   = 5'd2;
      start1 = (n == 6) || (n == 13);
      if (done1) break;
    end
    start1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("b30_latency",  32'(n), 28);
    chk("b30_swaps",    32'(swc1), 4);
    chk("b30_busy",     32'(busy_cyc1), 26);
    chk("b30_done",     32'(done_cnt1), 1);
    chk("b30_bad_addr", 32'(bad_addr1), 0);
    chk("b30_seen",     seen1, 32'hC000_0003);
    chk("b30_mem30",    mem1[30], 10);
    chk("b30_mem31",    mem1[31], 20);
    chk("b30_mem0",     mem1[0],  30);
    chk("b30_mem1",     mem1[1],  40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
